// File: rtl/dac_spi_writer_if.sv
// Sample-side and SPI/DAC-side signals of the dual-DAC SPI writer.
// slave is the writer itself; master is whoever drives the samples and watches the pins.
interface dac_spi_writer_if;
  logic        clk_sampling;
  logic        enableA;
  logic        enableB;
  logic [11:0] dacA_word;
  logic [11:0] dacB_word;
  logic        ovr_clr;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic        dac_ldac_n;
  logic        busy;
  logic        done;
  logic        overrun;

  modport master (
    output clk_sampling, enableA, enableB, dacA_word, dacB_word, ovr_clr,
    input  spi_sclk, spi_mosi, spi_cs_n, dac_ldac_n, busy, done, overrun
  );

  modport slave (
    input  clk_sampling, enableA, enableB, dacA_word, dacB_word, ovr_clr,
    output spi_sclk, spi_mosi, spi_cs_n, dac_ldac_n, busy, done, overrun
  );
endinterface

// File: rtl/dac_spi_writer.sv
// Serialises two latched 12-bit DAC words as MCP4922-style SPI frames (A then B),
// then strobes LDAC so both outputs update together. All outputs are registered.
module dac_spi_writer #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 2,
  parameter int unsigned LDAC_W  = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  dac_spi_writer_if.slave bus
);
  localparam int unsigned MaxDg  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CntMax = (MaxDg > LDAC_W) ? MaxDg : LDAC_W;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] DivLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(CS_GAP - 1);
  localparam logic [CntW-1:0] LdacLast = CntW'(LDAC_W - 1);

  typedef enum logic [2:0] {StIdle, StShiftA, StGapA, StShiftB, StGapB, StLdac} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     shreg_q, shreg_d;
  logic [15:0]     frame_b_q, frame_b_d;
  logic            sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, ldac_n_q, ldac_n_d;
  logic            busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
  logic [15:0]     frame_a;

  assign frame_a = {3'b001, bus.enableA, bus.dacA_word};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    frame_b_d = frame_b_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    ldac_n_d  = ldac_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    // A drop wins over a simultaneous clear.
    overrun_d = (overrun_q & ~bus.ovr_clr) | (bus.clk_sampling & busy_q);

    unique case (state_q)
      StIdle: begin
        if (bus.clk_sampling) begin
          shreg_d   = frame_a;
          frame_b_d = {3'b101, bus.enableB, bus.dacB_word};
          mosi_d    = frame_a[15];
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          bit_d     = '0;
          state_d   = StShiftA;
        end
      end
      StShiftA, StShiftB: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd15) begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = (state_q == StShiftA) ? StGapA : StGapB;
            end else begin
              bit_d   = bit_q + 4'd1;
              shreg_d = {shreg_q[14:0], 1'b0};
              mosi_d  = shreg_q[14];
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGapA: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          cs_n_d  = 1'b0;
          shreg_d = frame_b_q;
          mosi_d  = frame_b_q[15];
          state_d = StShiftB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGapB: begin
        if (cnt_q == GapLast) begin
          cnt_d    = '0;
          ldac_n_d = 1'b0;
          state_d  = StLdac;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLdac: begin
        if (cnt_q == LdacLast) begin
          cnt_d    = '0;
          ldac_n_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      frame_b_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      ldac_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      frame_b_q <= frame_b_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      ldac_n_q  <= ldac_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.spi_sclk   = sclk_q;
  assign bus.spi_mosi   = mosi_q;
  assign bus.spi_cs_n   = cs_n_q;
  assign bus.dac_ldac_n = ldac_n_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overrun    = overrun_q;
endmodule
